fetch_unit: RTL
===============

Name: fetch_unit

Overview:
PC register and instruction-fetch stage. It holds the architectural fetch PC and drives it into the existing PC incrementer. It takes the incremented value back as the sequential next PC. It issues one instruction-memory request at a time and hands fetched instructions to decode over a valid/ready handshake. Branch/jump redirects override the sequential path and squash any in-flight fetch.

Parameters:
pc_len, 32, width of PC and addresses
instr_len, 32, width of fetched instruction word
reset_vector, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_cur  output  pc_len  current fetch PC, feeds incrementer pc_in
pc_plus4  input  pc_len  incrementer pc_out (pc_cur + 4, combinational)
redirect_valid  input  1  redirect request from execute, single-cycle pulse or held
redirect_target  input  pc_len  new PC; bits [1:0] forced to 0 on capture
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  pc_len  fetch address, always equals pc_cur
imem_rsp_valid  input  1  response data valid, one cycle per accepted request
imem_rsp_data  input  instr_len  instruction word
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts instruction
if_instr  output  instr_len  buffered instruction
if_pc  output  pc_len  PC of buffered instruction

Behaviour:
- Reset is asynchronous and active-low. Values on reset:
  - pc_q = reset_vector; state = REQ; drop_q = 0
  - if_valid = 0; if_instr = 0; if_pc = 0
- All other updates happen on the rising edge of clk.
- pc_cur = pc_q at all times; imem_req_addr = pc_q.
- imem_req_valid = 1 only in state REQ.
- if_valid = 1 only in state HOLD.
- At most one request is outstanding.
- States:
  - REQ:
    - req_ready=1 -> WAIT.
    - redirect_valid=1 -> pc_q <= target. If req_ready=1 in the same cycle, the request is accepted with the old PC, drop_q <= 1 and the FSM goes to WAIT. Otherwise it stays in REQ.
  - WAIT:
    - rsp_valid=1 with drop_q=1 -> discard data, drop_q <= 0, go to REQ (pc_q already redirected).
    - rsp_valid=1 with drop_q=0 and no redirect -> capture if_instr <= rsp_data and if_pc <= pc_q, then pc_q <= pc_plus4, go to HOLD.
    - redirect_valid=1 with rsp_valid=1 -> discard data, pc_q <= target, drop_q <= 0, go to REQ.
    - redirect_valid=1 with no rsp -> pc_q <= target, drop_q <= 1, stay in WAIT.
  - HOLD:
    - if_ready=1 -> go to REQ.
    - redirect_valid=1 -> buffered instruction is squashed (if_valid drops the next cycle, even if if_ready=1 in the same cycle) and pc_q <= target. The FSM goes to REQ.
- Redirect always has priority over sequential advance.
- if_instr and if_pc are stable while if_valid=1 and if_ready=0.
- Arithmetic:
  - Next PC comes only from pc_plus4. No internal adder.
  - Wrap-around is modular: 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Latency:
  - Request accept to if_valid is 1 cycle after rsp_valid.
  - Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD).
- Reset asserted mid-transaction returns to REQ at reset_vector; a stale response arriving after deassert is not filtered, so memory must also be reset.
- rsp_valid outside WAIT is ignored.

Decomposition:
- Shared package proc_pkg holds:
  - fetch_state_t enum {REQ, WAIT, HOLD}
  - PC_LEN, INSTR_LEN
  - RESET_VECTOR constant
  - NOP encoding (used by bench)
- No sub-module needed. The existing pc incrementer is instantiated alongside fetch_unit at the next level up, not inside it.

Test Plan:
- Reset, then zero-latency memory with if_ready=1 -> requests at 0x0, 0x4, 0x8. if_pc sequence is 0x0, 0x4, 0x8 with the matching data words.
- Decode holds if_ready=0 for 5 cycles in HOLD -> if_instr and if_pc are unchanged, no new request is issued, and pc_cur = if_pc+4.
- Redirect to 0x100 while in WAIT, response arrives 2 cycles later -> response dropped. The next request address is 0x100, and if_pc=0x100 on the next delivered instruction.
- Redirect to 0x203 in the same cycle as imem_req_ready in REQ -> the old-PC request is accepted, its response is dropped, and the next request goes to 0x200.
- Redirect in HOLD with if_ready=1 in the same cycle -> the instruction is squashed, if_valid=0 the next cycle, and the next request goes to the target.
- reset_vector=32'hFFFF_FFFC -> the first fetch is 0xFFFF_FFFC and the second is 0x0000_0000. Asserting rst_n=0 in WAIT clears if_valid asynchronously and restarts at the vector.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared types and constants for the processor front end.
package proc_pkg;

  localparam int unsigned PC_LEN    = 32;
  localparam int unsigned INSTR_LEN = 32;

  localparam logic [PC_LEN-1:0]    RESET_VECTOR = 32'h0000_0000;
  localparam logic [INSTR_LEN-1:0] NOP          = 32'h0000_0013;

  typedef enum logic [1:0] {
    StReq,
    StWait,
    StHold
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Fetch PC register and single-outstanding instruction fetch stage with redirect squash.
module fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned       pc_len       = PC_LEN,
  parameter int unsigned       instr_len    = INSTR_LEN,
  parameter logic [pc_len-1:0] reset_vector = pc_len'(RESET_VECTOR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [pc_len-1:0]    pc_cur,
  input  logic [pc_len-1:0]    pc_plus4,
  input  logic                 redirect_valid,
  input  logic [pc_len-1:0]    redirect_target,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [pc_len-1:0]    imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [instr_len-1:0] imem_rsp_data,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [instr_len-1:0] if_instr,
  output logic [pc_len-1:0]    if_pc
);

  fetch_state_t         state_q;
  logic [pc_len-1:0]    pc_q;
  logic                 drop_q;
  logic [instr_len-1:0] if_instr_q;
  logic [pc_len-1:0]    if_pc_q;
  logic [pc_len-1:0]    target;

  assign target = redirect_target & ~pc_len'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StReq;
      pc_q       <= reset_vector;
      drop_q     <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
    end else begin
      unique case (state_q)
        StReq: begin
          if (redirect_valid) begin
            pc_q <= target;
            // Request already accepted with the old PC: its response must be discarded.
            if (imem_req_ready) begin
              drop_q  <= 1'b1;
              state_q <= StWait;
            end
          end else if (imem_req_ready) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (redirect_valid) begin
            pc_q <= target;
            if (imem_rsp_valid) begin
              drop_q  <= 1'b0;
              state_q <= StReq;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= StReq;
            end else begin
              if_instr_q <= imem_rsp_data;
              if_pc_q    <= pc_q;
              pc_q       <= pc_plus4;
              state_q    <= StHold;
            end
          end
        end
        StHold: begin
          if (redirect_valid) begin
            pc_q    <= target;
            state_q <= StReq;
          end else if (if_ready) begin
            state_q <= StReq;
          end
        end
        default: state_q <= StReq;
      endcase
    end
  end

  assign pc_cur         = pc_q;
  assign imem_req_addr  = pc_q;
  assign imem_req_valid = (state_q == StReq);
  assign if_valid       = (state_q == StHold);
  assign if_instr       = if_instr_q;
  assign if_pc          = if_pc_q;

endmodule
